// File: rtl/oam_dma_bus.sv
// oam_dma_bus: interposer between the CPU memory port and system memory.
//
// Provides the FF46 DMA register, a 160-byte OAM DMA engine (source page
// {srcHi,00} copied to OAM_BASE..OAM_BASE+DMA_LEN-1), and 127 bytes of
// high RAM at FF80-FFFE. HRAM and FF46 are internal and never forwarded to
// memory; they remain reachable while DMA owns the memory bus, whereas all
// other CPU reads return FF and CPU writes are dropped during a transfer.
// Both bus sides use a one-cycle registered-read protocol.
//
// Optional feature macro: OAMDMA_ECHO_FOLD_EN
//   defined   : source pages E0-FF fold down to C0-DF (echo RAM)
//   undefined : source page used exactly as written
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   cpuAddress     CPU address (valid every cycle)
//   cpuDataOut     CPU write data
//   cpuWriteEnable 1 = write, 0 = read
//   cpuDataIn      read data, one cycle after the address
//   memAddress     memory address
//   memDataOut     memory write data
//   memWriteEnable memory write strobe
//   memDataIn      memory read data, one cycle after memAddress
//   dmaActive      high from START through the final OAM write
module oam_dma_bus #(
    parameter logic [15:0] OAM_BASE = 16'hFE00,
    parameter int          DMA_LEN  = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpuAddress,
    input  logic [7:0]  cpuDataOut,
    input  logic        cpuWriteEnable,
    output logic [7:0]  cpuDataIn,
    output logic [15:0] memAddress,
    output logic [7:0]  memDataOut,
    output logic        memWriteEnable,
    input  logic [7:0]  memDataIn,
    output logic        dmaActive
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_WRITE} state_t;
    typedef enum logic [2:0] {SEL_ZERO, SEL_HRAM, SEL_REG, SEL_MEM, SEL_BLOCKED} sel_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  dma_reg_q, dma_reg_d;
    sel_t        rd_sel_q, rd_sel_d;

    logic [7:0]  hram_q [0:126];
    logic [7:0]  hram_rdata_q;

    logic        is_hram, is_reg, is_internal, reg_wr;
    logic [6:0]  hram_idx;

    function automatic logic [7:0] fold_src(input logic [7:0] v);
`ifdef OAMDMA_ECHO_FOLD_EN
        return (v >= 8'hE0) ? (v & 8'hDF) : v;
`else
        return v;
`endif
    endfunction

    // FF80-FFFE: low 7 bits index the array directly (FF80 -> 0, FFFE -> 126).
    assign is_hram     = (cpuAddress[15:7] == 9'h1FF) && (cpuAddress != 16'hFFFF);
    assign is_reg      = (cpuAddress == 16'hFF46);
    assign is_internal = is_hram || is_reg;
    assign reg_wr      = is_reg && cpuWriteEnable;
    assign hram_idx    = cpuAddress[6:0];
    assign dmaActive   = (state_q != S_IDLE);

    // HRAM survives reset, so it lives outside the reset domain.
    always_ff @(posedge clk) begin
        if (is_hram) begin
            if (cpuWriteEnable) hram_q[hram_idx] <= cpuDataOut;
            hram_rdata_q <= hram_q[hram_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'h00;
            src_hi_q  <= 8'h00;
            dma_reg_q <= 8'h00;
            rd_sel_q  <= SEL_ZERO;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            src_hi_q  <= src_hi_d;
            dma_reg_q <= dma_reg_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        src_hi_d  = src_hi_q;
        dma_reg_d = dma_reg_q;

        case (state_q)
            S_START: state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    idx_d   = 8'h00;
                end else begin
                    state_d = S_READ;
                    idx_d   = idx_q + 8'h01;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An FF46 write (re)starts from byte 0 in any state; the bus outputs
        // of the current cycle are unaffected, so a final WRITE still lands.
        if (reg_wr) begin
            dma_reg_d = cpuDataOut;
            src_hi_d  = fold_src(cpuDataOut);
            idx_d     = 8'h00;
            state_d   = S_START;
        end

        if (is_hram)        rd_sel_d = SEL_HRAM;
        else if (is_reg)    rd_sel_d = SEL_REG;
        else if (dmaActive) rd_sel_d = SEL_BLOCKED;
        else                rd_sel_d = SEL_MEM;
    end

    always_comb begin
        memAddress     = cpuAddress;
        memDataOut     = cpuDataOut;
        memWriteEnable = cpuWriteEnable && !is_internal;
        case (state_q)
            S_START: begin
                memAddress     = {src_hi_q, 8'h00};
                memWriteEnable = 1'b0;
            end
            S_READ: begin
                memAddress     = {src_hi_q, idx_q};
                memWriteEnable = 1'b0;
            end
            S_WRITE: begin
                memAddress     = OAM_BASE + {8'h00, idx_q};
                memDataOut     = memDataIn;
                memWriteEnable = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (rd_sel_q)
            SEL_HRAM:    cpuDataIn = hram_rdata_q;
            SEL_REG:     cpuDataIn = dma_reg_q;
            SEL_MEM:     cpuDataIn = memDataIn;
            SEL_BLOCKED: cpuDataIn = 8'hFF;
            default:     cpuDataIn = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_bus.sv
// Randomized scoreboard bench for oam_dma_bus with a behavioural memory.
module tb_oam_dma_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpuAddress;
    logic [7:0]  cpuDataOut;
    logic        cpuWriteEnable;
    logic [7:0]  cpuDataIn;
    logic [15:0] memAddress;
    logic [7:0]  memDataOut;
    logic        memWriteEnable;
    logic [7:0]  memDataIn;
    logic        dmaActive;

    always #5 clk = ~clk;

    oam_dma_bus dut (
        .clk(clk), .reset(reset),
        .cpuAddress(cpuAddress), .cpuDataOut(cpuDataOut),
        .cpuWriteEnable(cpuWriteEnable), .cpuDataIn(cpuDataIn),
        .memAddress(memAddress), .memDataOut(memDataOut),
        .memWriteEnable(memWriteEnable), .memDataIn(memDataIn),
        .dmaActive(dmaActive)
    );

    // Initial memory image: C0 page = i^5A, D0 page = ~(i^5A), E0 page = i+21.
    function automatic logic [7:0] init_pat(input logic [15:0] a);
        case (a[15:8])
            8'hC0:   return a[7:0] ^ 8'h5A;
            8'hD0:   return ~(a[7:0] ^ 8'h5A);
            8'hE0:   return a[7:0] + 8'h21;
            default: return (a == 16'h0000) ? 8'h31 : (a[7:0] ^ a[15:8] ^ 8'hA5);
        endcase
    endfunction

    bit [7:0] mem    [0:65535];
    bit       mem_wr [0:65535];
    int       wr_total, bad_wr, cyc;
    int       fe_cnt [0:255];

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return mem_wr[a] ? mem[a] : init_pat(a);
    endfunction

    always @(posedge clk) begin
        memDataIn <= mem_rd(memAddress);
        if (memWriteEnable) begin
            mem[memAddress]    <= memDataOut;
            mem_wr[memAddress] <= 1'b1;
            wr_total           <= wr_total + 1;
            if (memAddress[15:8] == 8'hFE)
                fe_cnt[memAddress[7:0]] <= fe_cnt[memAddress[7:0]] + 1;
            if (memAddress == 16'hFF46 || (memAddress[15:7] == 9'h1FF && memAddress != 16'hFFFF))
                bad_wr <= bad_wr + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    int          checks, failures;
    logic [7:0]  exp_q [$];
    bit          rd_issue;
    int          act_total, act_base;
    logic [7:0]  ref_hram [0:126];
    logic [7:0]  ref_dma;
    logic [7:0]  ref_mem [int];
    int          ref_start, ref_last;
    logic [15:0] last_hram;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit is_hram_a(input logic [15:0] a);
        return (a[15:7] == 9'h1FF) && (a != 16'hFFFF);
    endfunction

    // Transfer window: the cycle after edge c is busy when c in [start, last].
    function automatic bit blocked();
        return (cyc >= ref_start) && (cyc <= ref_last);
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (is_hram_a(a))   return ref_hram[int'(a - 16'hFF80)];
        if (a == 16'hFF46)  return ref_dma;
        if (blocked())      return 8'hFF;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_pat(a);
    endfunction

    task automatic monitor();
        bit         was;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            was = rd_issue;
            @(negedge clk);
            if (dmaActive) act_total++;
            if (was) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow actual=%0h required=none", cpuDataIn);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", cpuDataIn, e);
                end
            end
        end
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cpuAddress     = a;
        cpuWriteEnable = 1'b0;
        exp_q.push_back(ref_read(a));
        rd_issue = 1'b1;
        @(posedge clk); #1;
        rd_issue   = 1'b0;
        cpuAddress = 16'h0000;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bit internal_idle;
        cpuAddress     = a;
        cpuDataOut     = d;
        cpuWriteEnable = 1'b1;
        internal_idle  = (is_hram_a(a) || a == 16'hFF46) && !blocked();
        if (is_hram_a(a))     ref_hram[int'(a - 16'hFF80)] = d;
        else if (a == 16'hFF46) ref_dma = d;
        else if (!blocked())  ref_mem[int'(a)] = d;
        #1;
        if (internal_idle) chk("internal_we", memWriteEnable, 0);
        @(posedge clk); #1;
        if (a == 16'hFF46) begin
            ref_start = cyc;
            ref_last  = cyc + 320;
            act_base  = act_total;
        end
        cpuWriteEnable = 1'b0;
        cpuAddress     = 16'h0000;
    endtask

    task automatic rand_ops(input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 16'h7FFF));
                    else                           a = 16'h8000 + 16'($urandom_range(0, 255));
                    cpu_read(a);
                end
                1: begin
                    a = 16'hFF80 + 16'($urandom_range(0, 126));
                    cpu_write(a, 8'($urandom));
                    last_hram = a;
                end
                2: cpu_read(last_hram);
                3: cpu_read(16'hFF46);
                default: cpu_write(16'h8000 + 16'($urandom_range(0, 255)), 8'($urandom));
            endcase
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (dmaActive && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (dmaActive) begin
            checks++;
            failures++;
            $display("FAIL dma_timeout actual=active required=idle within %0d cycles", budget);
        end
    endtask

    task automatic chk_oam(input string name, input int lo, input int hi, input int pat);
        logic [7:0] e, b;
        for (int i = lo; i <= hi; i++) begin
            b = 8'(i);
            case (pat)
                0:       e = b ^ 8'h5A;
                1:       e = ~(b ^ 8'h5A);
                default: e = b + 8'h21;
            endcase
            chk(name, mem_rd(16'hFE00 + 16'(i)), e);
        end
    endtask

    int s9f, sa0, base0, wsnap;

    initial begin
        reset = 1'b1; cpuAddress = 16'h1234; cpuDataOut = 8'h00; cpuWriteEnable = 1'b0;
        ref_dma = 8'h00; ref_start = 0; ref_last = -1; last_hram = 16'hFF90;
        fork monitor(); join_none
        #3 reset = 1'b0;
        #9;
        chk("rst_dma_active", dmaActive, 0);
        chk("rst_cpu_data",   cpuDataIn, 8'h00);
        chk("rst_passthru",   memAddress, 16'h1234);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        // Idle pass-through and internal targets
        cpu_read(16'h0000);
        cpu_read(16'hFF46);
        cpu_write(16'hFF90, 8'h3C);
        cpu_read(16'hFF90);
        rand_ops(25);

        // Full transfer from C000 with traffic during DMA
        s9f = fe_cnt[8'h9F]; sa0 = fe_cnt[8'hA0];
        cpu_write(16'hFF46, 8'hC0);
        cpu_read(16'h0150);
        cpu_write(16'hC800, 8'h77);
        cpu_write(16'hFF90, 8'h3C);
        cpu_read(16'hFF90);
        cpu_read(16'hFF46);
        rand_ops(30);
        wait_idle(400);
        chk("active_len", act_total - act_base, 321);
        chk_oam("oam_c0", 0, 159, 0);
        chk("fe9f_once", fe_cnt[8'h9F] - s9f, 1);
        chk("fea0_cnt",  fe_cnt[8'hA0] - sa0, 0);
        chk("fea0_data", mem_rd(16'hFEA0), init_pat(16'hFEA0));
        chk("c800_kept", mem_rd(16'hC800), init_pat(16'hC800));
        rand_ops(20);

        // Restart at byte ~40 with a new source
        cpu_write(16'hFF46, 8'hC0);
        repeat (81) @(posedge clk); #1;
        cpu_write(16'hFF46, 8'hD0);
        wait_idle(400);
        chk("restart_len", act_total - act_base, 321);
        chk_oam("oam_d0", 0, 159, 1);

        // FF46 write coincident with the final WRITE cycle
        cpu_write(16'hFF46, 8'hC0);
        base0 = act_base;
        repeat (320) @(posedge clk); #1;
        cpu_write(16'hFF46, 8'hD0);
        chk("final_write_kept", mem_rd(16'hFE9F), 8'h9F ^ 8'h5A);
        chk("chain_active", dmaActive, 1);
        wait_idle(400);
        chk("chain_len", act_total - base0, 642);
        chk_oam("oam_chain", 0, 159, 1);

        // Reset during byte 80
        cpu_write(16'hFF46, 8'hC0);
        repeat (161) @(posedge clk);
        #2 reset = 1'b0;
        wsnap = wr_total; ref_last = -1; ref_dma = 8'h00;
        #1;
        chk("abort_active", dmaActive, 0);
        chk("abort_cpu_data", cpuDataIn, 8'h00);
        repeat (3) @(posedge clk); #1;
        chk("abort_no_writes", wr_total, wsnap);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_oam("abort_copied", 0, 79, 0);
        chk_oam("abort_untouched", 80, 159, 1);
        cpu_read(16'hFF46);
        cpu_read(last_hram);

        // Echo-page source
        cpu_write(16'hFF46, 8'hE0);
        wait_idle(400);
`ifdef OAMDMA_ECHO_FOLD_EN
        chk_oam("oam_echo", 0, 159, 0);
`else
        chk_oam("oam_echo", 0, 159, 2);
`endif
        cpu_read(16'hFF46);
        rand_ops(20);

        repeat (3) @(posedge clk); #1;
        chk("internal_never_fwd", bad_wr, 0);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_dma_bus.md
# oam_dma_bus

Bus interposer between the CPU core's memory port and system memory. It implements the DMA register at FF46, the 160-byte sprite-attribute (OAM) DMA engine, and the 127-byte high RAM at FF80–FFFE. HRAM stays reachable while DMA owns the memory bus. The block sits directly downstream of the CPU and upstream of the memory array, and uses the same one-cycle registered-read bus protocol on both sides.

## Interface
- `OAM_BASE`, 16'hFE00: destination base address.
- `DMA_LEN`, 160: bytes per transfer.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpuAddress`  in  16  CPU bus address; valid every cycle.
- `cpuDataOut`  in  8  CPU write data.
- `cpuWriteEnable`  in  1  1 = write, 0 = read.
- `cpuDataIn`  out  8  read data; returned one cycle after the address.
- `memAddress`  out  16  memory address.
- `memDataOut`  out  8  memory write data.
- `memWriteEnable`  out  1  1 = write, 0 = read.
- `memDataIn`  in  8  memory read data; valid one cycle after `memAddress`.
- `dmaActive`  out  1  high from the START state through the final write.

## Operation
- Address decode:
  - HRAM is FF80–FFFE. It is an internal registered array and is never forwarded to memory.
  - The DMA register is at FF46, is internal, and is never forwarded.
  - FFFF and all other addresses go to memory.
- FF46 write:
  - Stores `cpuDataOut` in `dmaReg`.
  - Loads source high byte `srcHi`, folded per Configuration.
  - Clears byte index `idx` to 0 and enters START.
  - This applies in every state. A write during an active transfer restarts it from byte 0 with the new source.
- FF46 read returns `dmaReg`. Reset value of `dmaReg` is 8'h00.
- Read-data select `rdSel` is registered at each edge from the current access: HRAM / REG / MEM / BLOCKED. `cpuDataIn` is then selected as:
  - HRAM: registered HRAM data.
  - REG: `dmaReg` as captured at that edge.
  - MEM: `memDataIn`.
  - BLOCKED: 8'hFF.
- States:
  - IDLE: memory port is combinational pass-through of the CPU port. `memWriteEnable = cpuWriteEnable` for non-internal addresses and 0 for HRAM/FF46.
  - START: one idle bus cycle with `memWriteEnable=0` and `memAddress={srcHi,8'h00}`; next state is READ.
  - READ: `memAddress={srcHi,idx}`, `memWriteEnable=0`; next state is WRITE.
  - WRITE: `memAddress=OAM_BASE+idx`, `memDataOut=memDataIn`, `memWriteEnable=1`. If `idx==DMA_LEN-1`, go to IDLE; otherwise `idx<=idx+1` and go to READ.
- While `dmaActive`:
  - CPU accesses to HRAM and FF46 behave normally.
  - All other CPU reads return 8'hFF on the next cycle.
  - All other CPU writes are dropped.
- `idx` is 8 bits and never exceeds `DMA_LEN-1`. No wrap into FEA0+ occurs.

## Timing
- Reset (`reset`=0) immediately forces:
  - state IDLE, `dmaActive=0`, `idx=0`, `srcHi=0`, `dmaReg=8'h00`;
  - `rdSel` to a ZERO select so `cpuDataIn=8'h00`;
  - HRAM contents unchanged.
  - Memory outputs follow IDLE pass-through.
- FF46 write sampled at edge T:
  - `dmaActive` rises after T; START occupies cycle T+1.
  - First READ is at T+2 and first WRITE at T+3.
  - Last WRITE is at T+1+2·DMA_LEN (T+321).
  - `dmaActive` falls after that edge, so it is high for 1+2·DMA_LEN = 321 cycles.
- CPU read latency is one cycle for every target, identical to plain memory.
- Reset asserted mid-transfer aborts it immediately. OAM bytes already written stay written, and no further writes issue.
- A simultaneous FF46 write and final WRITE cycle: the final write still issues, then the block enters START with the new source.

## Configuration
- `OAMDMA_ECHO_FOLD_EN`
  - Defined: source high bytes E0–FF fold to C0–DF (`srcHi = dmaReg & 8'hDF` when `dmaReg >= 8'hE0`). Other values are used unchanged.
  - Undefined: `srcHi = dmaReg` raw, so source E000–FF9F is read from memory as addressed.
  - `dmaReg` readback is the unfolded written value in both cases.

## Test plan
- Preload C000+i = i^8'h5A (i=0..159); CPU writes FF46=C0 → FE00+i == i^8'h5A for all i, `dmaActive` high exactly 321 cycles, FE9F written once, FEA0 untouched.
- During DMA, CPU reads 0150 → 8'hFF; CPU writes 8'h77 to C800 → C800 unchanged. CPU writes 8'h3C to FF90 and reads it back → 8'h3C one cycle later.
- FF46 read after writing 8'hC0 → 8'hC0. Idle read of 0000 holding 8'h31 → 8'h31 one cycle later; FF90 write never appears on `memWriteEnable`.
- Write FF46=C0, then FF46=D0 at byte 40 → FE00..FE9F all equal D000..D09F data, and `dmaActive` is high 321 cycles after the second write.
- Assert `reset` at byte 80 → `dmaActive`=0 and `cpuDataIn`=8'h00 at once, no further writes, and FE00..FE4F hold the copied data.
- Write FF46=E0 with C000/E000 preloaded differently → FE00.. gets C000 data if `OAMDMA_ECHO_FOLD_EN` is defined, E000 data if not.
